// File: rtl/xrv_div_pkg.sv
// rtl/xrv_div_pkg.sv - shared types and constants for the divide controller and divider
package xrv_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int OP_REM      = 1;
  localparam int OP_UNSIGNED = 0;
  localparam int DIV_LATENCY = 33;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/xrv_div.sv
// rtl/xrv_div.sv - iterative restoring divider, one quotient bit per cycle
module xrv_div
  import xrv_div_pkg::*;
(
  input  logic        clk,
  input  logic        rstb,
  input  logic        div_valid,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_dividend,
  input  logic [31:0] div_divisor,
  output logic        div_result_valid,
  output logic [31:0] div_result
);

  localparam logic [5:0] STEPS = 6'(DIV_LATENCY - 1);

  logic        run_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        rem_sel_q, negq_q, negr_q;
  logic        sgn_w;
  logic [32:0] sh_w, diff_w;

  assign sgn_w  = ~div_op[OP_UNSIGNED];
  assign sh_w   = {rem_q, quo_q[31]};
  assign diff_w = sh_w - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
    end else if (div_valid) begin
      run_q     <= 1'b1;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= (sgn_w && div_dividend[31]) ? neg32(div_dividend) : div_dividend;
      dvs_q     <= (sgn_w && div_divisor[31])  ? neg32(div_divisor)  : div_divisor;
      rem_sel_q <= div_op[OP_REM];
      negq_q    <= sgn_w & (div_dividend[31] ^ div_divisor[31]);
      negr_q    <= sgn_w & div_dividend[31];
    end else if (run_q) begin
      if (cnt_q == STEPS) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 6'd1;
        // Borrow out of the 33-bit trial subtraction means the divisor did not fit
        if (!diff_w[32]) begin
          rem_q <= diff_w[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= sh_w[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
      end
    end
  end

  assign div_result_valid = run_q && (cnt_q == STEPS);
  assign div_result = rem_sel_q ? (negr_q ? neg32(rem_q) : rem_q)
                                : (negq_q ? neg32(quo_q) : quo_q);

endmodule

// File: rtl/xrv_div_ctrl.sv
// rtl/xrv_div_ctrl.sv - RISC-V M-extension divide controller with fast paths, flush and drain
module xrv_div_ctrl
  import xrv_div_pkg::*;
(
  input  logic        clk,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        accept, is_signed, div0, ovf, fast;
  logic [31:0] dvd_q, dvs_q, data_q;
  logic [4:0]  rd_q;
  logic        neg_q, rem_op_q, div_valid_q;
  logic        div_valid, div_result_valid;
  logic [31:0] div_result;

  assign accept    = req_valid & req_ready;
  assign is_signed = ~req_op[OP_UNSIGNED];
  assign div0      = (req_rs2 == 32'd0);
  assign ovf       = is_signed & (req_rs1 == INT_MIN) & (req_rs2 == 32'hFFFF_FFFF);
  assign fast      = div0 | ovf;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = fast ? ST_RESP : ST_CALC;
      ST_CALC: begin
        if (div_result_valid) state_d = flush ? ST_IDLE : ST_RESP;
        else if (flush)       state_d = ST_DRAIN;
      end
      ST_DRAIN: if (div_result_valid) state_d = ST_IDLE;
      ST_RESP:  if (flush || rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) & ~flush;
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
  end

  // The divider always runs unsigned on magnitudes; sign fixup happens at capture
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      neg_q       <= 1'b0;
      rem_op_q    <= 1'b0;
      div_valid_q <= 1'b0;
    end else if (accept) begin
      rd_q        <= req_rd;
      rem_op_q    <= req_op[OP_REM];
      dvd_q       <= (is_signed && req_rs1[31]) ? neg32(req_rs1) : req_rs1;
      dvs_q       <= (is_signed && req_rs2[31]) ? neg32(req_rs2) : req_rs2;
      neg_q       <= is_signed & (req_op[OP_REM] ? req_rs1[31] : (req_rs1[31] ^ req_rs2[31]));
      div_valid_q <= ~fast;
      if (div0)     data_q <= req_op[OP_REM] ? req_rs1 : DIV0_QUOTIENT;
      else if (ovf) data_q <= req_op[OP_REM] ? 32'd0 : INT_MIN;
    end else begin
      div_valid_q <= 1'b0;
      if (state_q == ST_CALC && div_result_valid && !flush)
        data_q <= neg_q ? neg32(div_result) : div_result;
    end
  end

  assign div_valid = div_valid_q;
  assign rsp_data  = data_q;
  assign rsp_rd    = rd_q;

  xrv_div u_div (
    .clk              (clk),
    .rstb             (rstb),
    .div_valid        (div_valid),
    .div_op           ({rem_op_q, 1'b1}),
    .div_dividend     (dvd_q),
    .div_divisor      (dvs_q),
    .div_result_valid (div_result_valid),
    .div_result       (div_result)
  );

endmodule

// File: tb/tb_xrv_div_ctrl.sv
// tb/tb_xrv_div_ctrl.sv - directed self-checking bench for xrv_div_ctrl
module tb_xrv_div_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMS = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  xrv_div_ctrl dut (
    .clk       (clk),
    .rstb      (rstb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_rd    (req_rd),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_rd    (rsp_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.div_valid === 1'b1) starts++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstb = 1'b1;
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'd0 || rsp_rd !== 5'd0 ||
        dut.div_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b busy=%b data=%h rd=%h dv=%b required all zero",
               rsp_valid, busy, rsp_data, rsp_rd, dut.div_valid);
    end
    @(negedge clk); @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready got=%b required=1", req_ready);
    end
  endtask

  task automatic test_signed;
    int lat; int s0;
    s0 = starts;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_rsp(lat);
    checks++;
    if (lat !== 35 || rsp_data !== 32'hFFFF_FFFD || rsp_rd !== 5'd3) begin
      failures++;
      $display("FAIL div_signed got lat=%0d data=%h rd=%0d required lat=35 data=fffffffd rd=3",
               lat, rsp_data, rsp_rd);
    end
    finish_rsp();
    checks++;
    if (starts - s0 !== 1) begin
      failures++; $display("FAIL div_signed_starts got=%0d required=1", starts - s0);
    end
    issue(OP_REMS, 32'hFFFF_FFF9, 32'd2, 5'd4);
    wait_rsp(lat);
    checks++;
    if (lat !== 35 || rsp_data !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL rem_signed got lat=%0d data=%h required lat=35 data=ffffffff", lat, rsp_data);
    end
    finish_rsp();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rem_signed_idle busy got=%b required=0", busy);
    end
  endtask

  task automatic test_div_zero;
    int lat; int s0;
    s0 = starts;
    issue(OP_DIVU, 32'd100, 32'd0, 5'd5);
    wait_rsp(lat);
    checks++;
    if (lat !== 1 || rsp_data !== 32'hFFFF_FFFF || rsp_rd !== 5'd5) begin
      failures++;
      $display("FAIL divu_zero got lat=%0d data=%h rd=%0d required lat=1 data=ffffffff rd=5",
               lat, rsp_data, rsp_rd);
    end
    finish_rsp();
    issue(OP_REMU, 32'd100, 32'd0, 5'd6);
    wait_rsp(lat);
    checks++;
    if (lat !== 1 || rsp_data !== 32'd100) begin
      failures++;
      $display("FAIL remu_zero got lat=%0d data=%0d required lat=1 data=100", lat, rsp_data);
    end
    finish_rsp();
    checks++;
    if (starts !== s0) begin
      failures++; $display("FAIL div_zero_no_start got=%0d required=0", starts - s0);
    end
  endtask

  task automatic test_overflow;
    int lat; int s0;
    s0 = starts;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    wait_rsp(lat);
    checks++;
    if (lat !== 1 || rsp_data !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_ovf got lat=%0d data=%h required lat=1 data=80000000", lat, rsp_data);
    end
    finish_rsp();
    issue(OP_REMS, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    wait_rsp(lat);
    checks++;
    if (lat !== 1 || rsp_data !== 32'd0) begin
      failures++;
      $display("FAIL rem_ovf got lat=%0d data=%h required lat=1 data=0", lat, rsp_data);
    end
    finish_rsp();
    checks++;
    if (starts !== s0) begin
      failures++; $display("FAIL ovf_no_start got=%0d required=0", starts - s0);
    end
  endtask

  task automatic test_backpressure;
    int lat; int bad;
    issue(OP_DIVU, 32'd20, 32'd3, 5'd7);
    wait_rsp(lat);
    checks++;
    if (lat !== 35) begin
      failures++; $display("FAIL bp_latency got=%0d required=35", lat);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd6 || rsp_rd !== 5'd7 || req_ready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold bad_cycles=%0d required=0 (last data=%0d rd=%0d)", bad, rsp_data, rsp_rd);
    end
    finish_rsp();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got busy=%b v=%b rdy=%b required 0 0 1", busy, rsp_valid, req_ready);
    end
  endtask

  task automatic test_flush_idle;
    req_op = OP_DIVU; req_rs1 = 32'd50; req_rs2 = 32'd5; req_rd = 5'd1;
    req_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL flush_idle_ready got=%b required=0", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL flush_idle_accepted got busy=%b v=%b required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_flush_resp;
    int lat;
    issue(OP_DIVU, 32'd7, 32'd0, 5'd2);
    wait_rsp(lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (lat !== 1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_resp got lat=%0d v=%b busy=%b required 1 0 0", lat, rsp_valid, busy);
    end
  endtask

  task automatic test_flush_drain;
    int lat; int bad;
    issue(OP_DIVU, 32'd20, 32'd3, 5'd10);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bad = 0;
    for (int c = 11; c <= 34; c++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL drain_hold bad_cycles=%0d required=0", bad);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_done got busy=%b rdy=%b v=%b required 0 1 0", busy, req_ready, rsp_valid);
    end
    issue(OP_REMU, 32'd20, 32'd3, 5'd11);
    wait_rsp(lat);
    checks++;
    if (lat !== 35 || rsp_data !== 32'd2 || rsp_rd !== 5'd11) begin
      failures++;
      $display("FAIL remu_after_drain got lat=%0d data=%0d rd=%0d required 35 2 11", lat, rsp_data, rsp_rd);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid;
    int lat; int bad; int s0;
    issue(OP_DIV, 32'd100, 32'd7, 5'd12);
    repeat (14) @(negedge clk);
    rstb = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'd0 || rsp_rd !== 5'd0 ||
        dut.div_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got v=%b busy=%b data=%h rd=%h dv=%b required all zero",
               rsp_valid, busy, rsp_data, rsp_rd, dut.div_valid);
    end
    @(negedge clk); @(negedge clk);
    rstb = 1'b1;
    bad = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL reset_mid_quiet bad_cycles=%0d required=0", bad);
    end
    s0 = starts;
    issue(OP_DIV, 32'd9, 32'd3, 5'd13);
    wait_rsp(lat);
    checks++;
    if (lat !== 35 || rsp_data !== 32'd3 || rsp_rd !== 5'd13 || starts - s0 !== 1) begin
      failures++;
      $display("FAIL div_after_reset got lat=%0d data=%0d rd=%0d starts=%0d required 35 3 13 1",
               lat, rsp_data, rsp_rd, starts - s0);
    end
    finish_rsp();
  endtask

  initial begin
    req_valid = 1'b0; req_op = 2'b00; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    flush = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_flush_idle();
    test_flush_resp();
    test_flush_drain();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xrv_div_ctrl.md
XRV_DIV_CTRL -- requirements
Module: xrv_div_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rstb.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstb  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  issue request from the pipeline.
REQ-005 req_ready  output  1  request accepted when req_valid & req_ready are high at a clk edge.
REQ-006 req_op  input  2  bit1: 0 DIV, 1 REM; bit0: 0 signed, 1 unsigned.
REQ-007 req_rs1 / req_rs2  input  32 each  dividend / divisor.
REQ-008 req_rd  input  5  destination tag, returned unchanged.
REQ-009 flush  input  1  kill any in-flight or pending operation.
REQ-010 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-011 rsp_data  output  32  RISC-V M-extension result; rsp_rd  output  5  tag.
REQ-012 busy  output  1  high whenever state != IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DRAIN and RESP; reset state IDLE.
REQ-014 req_ready SHALL equal (state==IDLE) & ~flush.
REQ-015 On acceptance: operands, op and tag registered; fast-path check decides next state.
REQ-016 Fast path, divisor==0: q=0xFFFFFFFF, r=rs1; next state RESP.
REQ-017 Fast path, signed & rs1==0x80000000 & rs2==0xFFFFFFFF: q=0x80000000, r=0; next state RESP.
REQ-018 Otherwise next state CALC; a single-cycle div_valid pulse SHALL be issued in the first CALC cycle.
REQ-019 The divider SHALL always run unsigned (optype bit0=1); dividend and divisor are operand magnitudes (two's-complement negate if signed and bit31 set).
REQ-020 Sign fixup: negate quotient if signed & rs1[31]^rs2[31]; negate remainder if signed & rs1[31].
REQ-021 Divider result SHALL appear 33 cycles after div_valid; the controller captures it on div_result_valid in CALC and moves to RESP.
REQ-022 Latency, acceptance edge ending cycle T: fast path rsp_valid in T+1; normal path rsp_valid in T+35.
REQ-023 In RESP: rsp_valid high, rsp_data/rsp_rd stable until rsp_ready; then IDLE in the next cycle.
REQ-024 flush in IDLE: no effect, and a same-cycle request is not accepted.
REQ-025 flush in RESP: the response is dropped and the next state is IDLE, even if rsp_ready is high in the same cycle.
REQ-026 flush in CALC before div_result_valid: next state DRAIN.
REQ-027 flush in CALC in the same cycle as div_result_valid: the result is discarded and the next state is IDLE.
REQ-028 DRAIN SHALL wait for div_result_valid, discard it, then go to IDLE; no div_valid is issued while the divider is running.
REQ-029 div_result_valid seen outside CALC/DRAIN SHALL be ignored.

Reset
REQ-030 While rstb is low: state IDLE, rsp_valid=0, div_valid=0, rsp_data=0, rsp_rd=0, busy=0.
REQ-031 Reset mid-CALC/DRAIN SHALL also reset the divider instance; no response follows reset release.

Structure
REQ-032 Package xrv_div_pkg SHALL hold: the state enum, the op bit positions (OP_REM=1, OP_UNSIGNED=0), DIV_LATENCY=33, DIV0_QUOTIENT=32'hFFFFFFFF and INT_MIN=32'h80000000.
REQ-033 Exactly one sub-module SHALL be instantiated: the existing iterative divider xrv_div, sharing clk/rstb.

Verification
REQ-034 DIV signed 0xFFFFFFF9 / 2 -> rsp_data 0xFFFFFFFD at T+35; REM same operands -> 0xFFFFFFFF.
REQ-035 DIVU 100 / 0 -> 0xFFFFFFFF at T+1; REMU 100 / 0 -> 100 at T+1; divider never started.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both at T+1.
REQ-037 DIVU 20 / 3 with rsp_ready low for 10 cycles -> rsp_data 6, rsp_rd held stable; req_ready low until the handshake.
REQ-038 flush at T+10 -> no response, busy high, req_ready low until the drain completes (T+34), then REMU 20 / 3 -> 2.
REQ-039 rstb low at T+15 of a DIV -> all outputs zero; the next DIV 9 / 3 -> 3 at the expected latency.
